// File: rtl/pulse_cmd_pkg.sv
// Shared command-word definitions for the pulse generator path.
// Opcodes, field slices and arbiter state encoding.
package pulse_cmd_pkg;

    localparam logic [7:0] CMD_RESET_CLOCK      = 8'd0;
    localparam logic [7:0] CMD_SEND_PULSE       = 8'd1;
    localparam logic [7:0] CMD_SET_PERIOD       = 8'd2;
    localparam logic [7:0] CMD_SET_PHASE_MEAS   = 8'd3;
    localparam logic [7:0] CMD_RESET_PHASE_MEAS = 8'd4;

    localparam int CMD_MSB    = 31;
    localparam int CMD_LSB    = 24;
    localparam int COARSE_MSB = 23;
    localparam int COARSE_LSB = 8;
    localparam int FINE_MSB   = 7;
    localparam int FINE_LSB   = 0;
    localparam int PERIOD_MSB = 23;
    localparam int PERIOD_LSB = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [7:0] cmd_of(
        input logic [31:0] w
    );
        return w[CMD_MSB:CMD_LSB];
    endfunction

    function automatic logic [15:0] coarse_of(
        input logic [31:0] w
    );
        return w[COARSE_MSB:COARSE_LSB];
    endfunction

    function automatic logic [7:0] fine_of(
        input logic [31:0] w
    );
        return w[FINE_MSB:FINE_LSB];
    endfunction

    function automatic logic [23:0] period_of(
        input logic [31:0] w
    );
        return w[PERIOD_MSB:PERIOD_LSB];
    endfunction

endpackage

// File: rtl/pulse_cmd_arbiter_rr_pick.sv
// Round-robin selector: first valid index at or above ptr,
// wrapping around; purely combinational.
module rr_pick
    import pulse_cmd_pkg::*;
#(
    parameter int N  = 4,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [GW-1:0] ptr,
    output logic [GW-1:0] winner,
    output logic          any_valid
);

    int idx;

    // Scan farthest-first so the nearest valid index wins
    always_comb begin
        winner    = '0;
        any_valid = |valid;
        idx       = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (valid[idx]) begin
                winner = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/pulse_cmd_arbiter.sv
// Packet-granular round-robin arbiter in front of the pulse command FIFO.
// Opcode filtering is built when PULSE_CMD_OPCODE_FILTER_EN is defined.
module pulse_cmd_arbiter
    import pulse_cmd_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 1024,
    parameter int MAX_OPCODE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ*32-1:0]      req_tdata,
    input  logic [NUM_REQ-1:0]         req_tvalid,
    input  logic [NUM_REQ-1:0]         req_tlast,
    output logic [NUM_REQ-1:0]         req_tready,
    input  logic                       fifo_almost_full,
    output logic                       fifo_wr,
    output logic [31:0]                fifo_din,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_evt,
    output logic [15:0]                drop_count
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

`ifdef PULSE_CMD_OPCODE_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    arb_state_e  state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] winner;
    logic [GW-1:0] next_ptr;
    logic [CW-1:0] idle_cnt;
    logic          any_valid;
    logic [31:0]   gdata;
    logic          gvalid;
    logic          glast;
    logic          accept;
    logic          legal;

    rr_pick #(
        .N  (NUM_REQ),
        .GW (GW)
    ) u_pick (
        .valid     (req_tvalid),
        .ptr       (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Mux the granted channel and drive its ready from FIFO space
    always_comb begin
        gdata      = '0;
        gvalid     = 1'b0;
        glast      = 1'b0;
        req_tready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GW'(i) == grant_id) begin
                gdata  = req_tdata[32*i +: 32];
                gvalid = req_tvalid[i];
                glast  = req_tlast[i];
                req_tready[i] = (state == GRANT) &&
                                !fifo_almost_full;
            end
        end
    end

    assign accept = (state == GRANT) && gvalid &&
                    !fifo_almost_full;

    assign legal = !FILTER_ON ||
                   (cmd_of(gdata) <= 8'(MAX_OPCODE));

    assign next_ptr = (grant_id == GW'(NUM_REQ - 1)) ?
                      '0 : grant_id + GW'(1);

    // Grant FSM: arbitrate in IDLE, forward words until tlast or timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            idle_cnt    <= '0;
            busy        <= 1'b0;
            fifo_wr     <= 1'b0;
            fifo_din    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            fifo_wr     <= 1'b0;
            timeout_evt <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        state    <= GRANT;
                        grant_id <= winner;
                        idle_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (legal) begin
                            fifo_wr  <= 1'b1;
                            fifo_din <= gdata;
                        end
                        if (glast) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end else if (!gvalid) begin
                        if (idle_cnt == CW'(TIMEOUT - 1)) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            rr_ptr      <= next_ptr;
                            idle_cnt    <= '0;
                            timeout_evt <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PULSE_CMD_OPCODE_FILTER_EN
    // Saturating count of consumed-but-discarded illegal words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count <= '0;
        end else if (accept && !legal &&
                     drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: doc/pulse_cmd_arbiter.md
Name: pulse_cmd_arbiter

Overview:
- Shares the pulse generator's 32-bit command FIFO between NUM_REQ independent command sources (host AXI bridge, timing-sync loop, calibration sequencer, ...).
- Grants one requester at a time using round-robin arbitration. A grant is held for a whole multi-word packet, delimited by tlast, so a requester's set_period followed by send_pulse is never interleaved with another requester's words.
- Validates opcodes and releases a stalled grant after a timeout.
- Sits between the requesters and the write side of the FIFO that feeds pulse_gen.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 1024: idle cycles allowed mid-packet before the grant is forcibly released, ≥2.
- MAX_OPCODE, 4: highest legal command byte (0 reset_clock, 1 send_pulse, 2 set_period, 3 set_phase_meas_mode, 4 reset_phase_meas_mode).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- req_tdata  in  NUM_REQ*32  command words, requester i occupies [32i+31:32i].
- req_tvalid  in  NUM_REQ  per-requester valid.
- req_tlast  in  NUM_REQ  marks the last word of a packet.
- req_tready  out  NUM_REQ  per-requester ready.
- fifo_almost_full  in  1  high when ≤1 free entry remains in the command FIFO.
- fifo_wr  out  1  FIFO write strobe.
- fifo_din  out  32  FIFO write data.
- grant_id  out  clog2(NUM_REQ)  current or last granted requester.
- busy  out  1  high while in state GRANT.
- timeout_evt  out  1  one-cycle pulse when a grant is force-released.
- drop_count  out  16  count of illegal commands dropped, saturating.

Behaviour:
- Reset (asynchronous, rst high): state IDLE, rr_ptr 0, grant_id 0, fifo_wr 0, fifo_din 0, req_tready 0, busy 0, timeout_evt 0, drop_count 0, idle counter 0. Reset asserted mid-packet abandons the packet; no partial write is emitted after reset.
- State IDLE:
  - If any req_tvalid is high, select the first valid index scanning from rr_ptr upward with wrap.
  - Next cycle: grant_id = winner, state GRANT.
  - No word is accepted in IDLE, so arbitration costs 1 cycle.
- State GRANT:
  - req_tready[grant_id] = !fifo_almost_full, combinational from the port. All other tready bits are 0.
  - Accept means tvalid && tready on the granted channel.
  - On accept: next cycle fifo_wr=1 and fifo_din = accepted word. Latency is 1 cycle, and at most one write per cycle.
  - The almost_full margin covers the registered write.
  - Accept with tlast: state IDLE, rr_ptr = (grant_id+1) mod NUM_REQ.
  - Idle counter: cleared on every accept; otherwise increments while tvalid[grant_id] is low. Reaching TIMEOUT: state IDLE, rr_ptr advances as above, timeout_evt pulses 1 cycle.
  - A stall caused by fifo_almost_full (valid high, ready low) does not count toward the timeout.
- Opcode check: an accepted word with byte [31:24] > MAX_OPCODE is consumed (tready behaves normally) but is not written; fifo_wr stays 0 that cycle. drop_count increments and saturates at 0xFFFF. tlast on a dropped word still ends the packet.
- Fairness: after a packet completes, its requester has the lowest priority in the next arbitration. A requester raising tvalid while another holds the grant waits at most NUM_REQ-1 packets.
- Outputs are fifo_wr, fifo_din, grant_id, busy, timeout_evt and drop_count, all registered. Only req_tready is combinational.

Optional Feature:
- Macro PULSE_CMD_OPCODE_FILTER_EN.
- Defined: the opcode check above is applied.
- Undefined: every accepted word is written regardless of opcode, and drop_count is tied to 0.

Decomposition:
- Shared package pulse_cmd_pkg holds:
  - opcode localparams (CMD_RESET_CLOCK=0 … CMD_RESET_PHASE_MEAS=4);
  - field slices: command [31:24], coarse [23:8], fine [7:0], period [23:0];
  - the state encoding (IDLE, GRANT).
- pulse_gen and the host driver model both use this package.
- One sub-module, rr_pick: combinational round-robin selector taking valid vector and rr_ptr, giving winner index and any_valid.

Test Plan:
- Single packet: requester 1 sends 0x02000100 (set_period 256) then 0x01000305 (tlast) → fifo_din sequence 0x02000100, 0x01000305; each write 1 cycle after accept; busy falls after the last word.
- Fairness: all 4 requesters hold continuous 2-word packets → grant order 0,1,2,3,0; no interleaving within any packet.
- Backpressure: fifo_almost_full held high for 10 cycles mid-packet → tready 0, no fifo_wr, no timeout_evt; the packet resumes intact afterwards.
- Timeout (TIMEOUT=8): requester 2 sends one non-last word then drops valid → timeout_evt at idle count 8, grant passes to the pending requester 3.
- Illegal opcode with filter enabled: word 0x07000000 → no write, drop_count=1, next legal word written. With filter disabled, 0x07000000 is written and drop_count stays 0.
- Reset mid-packet: assert rst while requester 0 is granted → all outputs 0 immediately; after release, arbitration restarts from index 0.
